fpga_robots_game_tm_engine: RTL and testbench
=============================================

// Module: fpga_robots_game_tm_engine
// PURPOSE
//  Tile-map access engine; sits directly upstream of the video generator's external tile map port (tm_adr/tm_wrt/tm_wen/tm_red).
//  Turns game-logic cell commands (x,y in the 120x96 play grid) into byte accesses.
//  Does read-modify-write of the 2-bit cell fields, direct byte writes (status columns), and whole-play-area clear sweeps.
//  Memory map: byte addr = {y[6:1], x[6:0]}; even y -> bits[1:0], odd y -> bits[3:2]; bits[7:4] = work nibble.
// PARAMETERS
//  PA_COLS  120    play-area columns (byte columns swept by CLEAR)
//  PA_ROWS  96     play-area cell rows (CLEAR sweeps PA_ROWS/2 byte rows)
//  CLR_VAL  8'h00  byte written by CLEAR
// PORTS
//  clk        in   1   clock, ~65MHz, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine idle; command accepted when valid&&ready at a rising edge
//  cmd_op     in   2   0 READ_CELL, 1 WRITE_CELL, 2 WRITE_BYTE, 3 CLEAR
//  cmd_x      in   7   column 0-127
//  cmd_y      in   7   cell row 0-95
//  cmd_dat    in   8   WRITE_CELL: [1:0] new cell; WRITE_BYTE: full byte
//  rsp_valid  out  1   one-cycle completion pulse, no backpressure
//  rsp_dat    out  8   READ_CELL: {2'b0, work nibble, cell}; else 0
//  rsp_err    out  1   qualifies rsp_valid: command rejected, no memory access
//  tm_adr     out  13  tile map address
//  tm_wrt     out  8   tile map write data
//  tm_wen     out  1   tile map write enable
//  tm_red     in   8   read data, valid one clock after tm_adr presented
// BEHAVIOUR
//  Reset (async): state IDLE; cmd_ready=1 after release.
//   tm_adr=0, tm_wrt=0, tm_wen=0, rsp_valid=0, rsp_dat=0, rsp_err=0 immediately on assertion.
//  tm_*/rsp_* driven only from registers; no combinational path from cmd_* to any output.
//  States: IDLE, RD, MOD, WB, CLR, ERR. cmd_ready=1 only in IDLE.
//  Accept at edge E0 latches op/x/y/dat; the next state is decided from op:
//   READ_CELL/WRITE_CELL: RD (E0-E1) drives tm_adr, tm_wen=0; MOD (E1-E2) then uses tm_red.
//    WRITE_CELL in MOD: tm_wen=1, tm_wrt=tm_red with field y[0]?[3:2]:[1:0] replaced by dat[1:0]; other 6 bits kept.
//    READ_CELL in MOD: tm_wen=0, rsp_dat={2'b0,tm_red[7:4],field}.
//    rsp_valid=1 in MOD; IDLE from E2 (3 cycles/op incl. accept).
//   WRITE_BYTE: WB (E0-E1) tm_adr={y[6:1],x}, tm_wrt=dat, tm_wen=1, rsp_valid=1; IDLE from E1. Any x 0-127 allowed.
//   CLEAR: CLR writes CLR_VAL at one byte per cycle with tm_wen=1.
//    Byte row r=0..PA_ROWS/2-1 (outer), col c=0..PA_COLS-1 (inner); status columns PA_COLS..127 never touched.
//    After the last write (addr {47,119}) rsp_valid=1 for one cycle with tm_wen=0, then IDLE.
//    Total PA_COLS*PA_ROWS/2 = 5760 write cycles.
//  Range check, READ_CELL/WRITE_CELL: x>=PA_COLS or y>=PA_ROWS -> ERR (E0-E1): rsp_valid=1, rsp_err=1, tm_wen=0; IDLE from E1.
//   WRITE_BYTE: y>=PA_ROWS -> ERR likewise.
//  rsp_err=0 on every other rsp_valid. rsp_dat/rsp_err are meaningful only while rsp_valid=1.
//  tm_wen is 0 in IDLE, RD, ERR and the CLEAR completion cycle.
//  cmd_* ignored outside IDLE; holding cmd_valid high issues back-to-back commands, each accepted on returning to IDLE.
//  Counters: col counter wraps PA_COLS-1 -> 0 and increments the row; row terminal PA_ROWS/2-1 ends the sweep (no 13-bit overflow).
//  Reset mid-operation: op abandoned, no further writes, no rsp_valid. Partial CLEAR leaves the remaining bytes unchanged.
// TESTING
//  Reset: assert rst between edges -> outputs 0 at once; after release cmd_ready=1, tm_wen=0.
//  Mem[0x10A]=0x5A; WRITE_CELL x=10,y=5,dat=3 -> RD adr 0x10A, MOD tm_wrt=0x5E tm_wen=1, rsp_valid 2nd cycle after accept, err=0.
//  Mem[0x10A]=0x5E; READ_CELL x=10,y=4 -> rsp_dat=0x16, no tm_wen pulse, cmd_ready back 3 cycles after accept.
//  WRITE_CELL x=120,y=0 -> rsp_valid+rsp_err the cycle after accept, zero tm_wen cycles; WRITE_BYTE x=120,y=0,dat=0x3F -> adr 0x078, wen 1 cycle.
//  CLEAR, mem all 0xFF -> exactly 5760 tm_wen cycles, last adr 0x17F7, all play bytes 0x00, 0x078 etc still 0xFF/0x3F, then rsp_valid.
//  Async rst after 100 CLEAR writes -> tm_wen drops immediately; bytes from {0,100} on unchanged; no rsp_valid; next READ_CELL works.

Source files
------------

// File: rtl/fpga_robots_game_tm_engine.sv
// Tile-map access engine: turns play-grid cell commands into byte accesses on the
// video generator's tile map port (read-modify-write of 2-bit cell fields,
// direct byte writes, whole play-area clear sweep).
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a command, cmd_ready=1
// S_RD   | cell address on tm_adr, waiting for tm_red
// S_MOD  | cell field merged/extracted, write-back (WRITE_CELL), response
// S_WB   | direct byte write, response
// S_CLR  | clear sweep one byte per cycle, then completion response
// S_ERR  | out-of-range command rejected, error response
//
// All outputs are registers loaded from the next-state logic, so tm_red is
// sampled at the RD->MOD edge and cmd_* only ever reach outputs through flops.
module fpga_robots_game_tm_engine #(
    parameter int          PA_COLS = 120,
    parameter int          PA_ROWS = 96,
    parameter logic [7:0]  CLR_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [7:0]  cmd_dat,
    output logic        rsp_valid,
    output logic [7:0]  rsp_dat,
    output logic        rsp_err,
    output logic [12:0] tm_adr,
    output logic [7:0]  tm_wrt,
    output logic        tm_wen,
    input  logic [7:0]  tm_red
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MOD, S_WB, S_CLR, S_ERR} state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WCELL = 2'd1;
    localparam logic [1:0] OP_WBYTE = 2'd2;

    localparam logic [6:0] LP_COL_LAST = 7'(PA_COLS - 1);
    localparam logic [6:0] LP_Y_LAST   = 7'(PA_ROWS - 1);
    localparam logic [5:0] LP_ROW_LAST = 6'(PA_ROWS / 2 - 1);

    state_t      r_state, w_state;
    logic [1:0]  r_op, w_op;
    logic        r_y0, w_y0;
    logic [1:0]  r_cell, w_cell;
    logic [12:0] r_tm_adr, w_tm_adr;
    logic [7:0]  r_tm_wrt, w_tm_wrt;
    logic        r_tm_wen, w_tm_wen;
    logic        r_rsp_valid, w_rsp_valid;
    logic [7:0]  r_rsp_dat, w_rsp_dat;
    logic        r_rsp_err, w_rsp_err;
    logic        r_cmd_ready;

    logic        w_x_bad, w_y_bad;
    logic [1:0]  w_field;

    assign w_x_bad = (cmd_x > LP_COL_LAST);
    assign w_y_bad = (cmd_y > LP_Y_LAST);
    assign w_field = r_y0 ? tm_red[3:2] : tm_red[1:0];

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_y0        = r_y0;
        w_cell      = r_cell;
        w_tm_adr    = r_tm_adr;
        w_tm_wrt    = r_tm_wrt;
        w_tm_wen    = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_dat   = 8'h00;
        w_rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_op   = cmd_op;
                    w_y0   = cmd_y[0];
                    w_cell = cmd_dat[1:0];
                    case (cmd_op)
                        OP_READ, OP_WCELL: begin
                            if (w_x_bad || w_y_bad) begin
                                w_state     = S_ERR;
                                w_rsp_valid = 1'b1;
                                w_rsp_err   = 1'b1;
                            end else begin
                                w_state  = S_RD;
                                w_tm_adr = {cmd_y[6:1], cmd_x};
                            end
                        end
                        OP_WBYTE: begin
                            if (w_y_bad) begin
                                w_state     = S_ERR;
                                w_rsp_valid = 1'b1;
                                w_rsp_err   = 1'b1;
                            end else begin
                                w_state     = S_WB;
                                w_tm_adr    = {cmd_y[6:1], cmd_x};
                                w_tm_wrt    = cmd_dat;
                                w_tm_wen    = 1'b1;
                                w_rsp_valid = 1'b1;
                            end
                        end
                        default: begin
                            w_state  = S_CLR;
                            w_tm_adr = 13'd0;
                            w_tm_wrt = CLR_VAL;
                            w_tm_wen = 1'b1;
                        end
                    endcase
                end
            end
            S_RD: begin
                w_state     = S_MOD;
                w_rsp_valid = 1'b1;
                if (r_op == OP_WCELL) begin
                    w_tm_wen = 1'b1;
                    w_tm_wrt = r_y0 ? {tm_red[7:4], r_cell, tm_red[1:0]}
                                    : {tm_red[7:2], r_cell};
                end else begin
                    w_rsp_dat = {2'b00, tm_red[7:4], w_field};
                end
            end
            S_CLR: begin
                // rsp_valid only rises in CLR on the completion cycle
                if (r_rsp_valid) begin
                    w_state = S_IDLE;
                end else if (r_tm_adr == {LP_ROW_LAST, LP_COL_LAST}) begin
                    w_rsp_valid = 1'b1;
                end else begin
                    w_tm_wen = 1'b1;
                    if (r_tm_adr[6:0] == LP_COL_LAST) begin
                        w_tm_adr = {r_tm_adr[12:7] + 6'd1, 7'd0};
                    end else begin
                        w_tm_adr = {r_tm_adr[12:7], r_tm_adr[6:0] + 7'd1};
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 2'd0;
            r_y0        <= 1'b0;
            r_cell      <= 2'd0;
            r_tm_adr    <= 13'd0;
            r_tm_wrt    <= 8'h00;
            r_tm_wen    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_y0        <= w_y0;
            r_cell      <= w_cell;
            r_tm_adr    <= w_tm_adr;
            r_tm_wrt    <= w_tm_wrt;
            r_tm_wen    <= w_tm_wen;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_dat   <= w_rsp_dat;
            r_rsp_err   <= w_rsp_err;
            r_cmd_ready <= (w_state == S_IDLE);
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign tm_adr    = r_tm_adr;
    assign tm_wrt    = r_tm_wrt;
    assign tm_wen    = r_tm_wen;

endmodule

// File: tb/tb_fpga_robots_game_tm_engine.sv
// Directed bench for the tile-map engine with a behavioural tile map memory.
module tb_fpga_robots_game_tm_engine;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_dat;
    logic        rsp_valid;
    logic [7:0]  rsp_dat;
    logic        rsp_err;
    logic [12:0] tm_adr;
    logic [7:0]  tm_wrt;
    logic        tm_wen;
    logic [7:0]  tm_red;

    logic [7:0]  mem [0:8191];
    logic        fill_req;
    logic [7:0]  fill_val;
    logic        poke_req;
    logic [12:0] poke_adr;
    logic [7:0]  poke_dat;

    int          wen_cnt;
    int          rsp_cnt;
    logic [12:0] last_wen_adr;

    int          n_checks;
    int          n_fail;

    fpga_robots_game_tm_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .tm_adr    (tm_adr),
        .tm_wrt    (tm_wrt),
        .tm_wen    (tm_wen),
        .tm_red    (tm_red)
    );

    // 100 MHz bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tile map: read data available within the cycle the address is presented
    assign tm_red = mem[tm_adr];

    // Single writer for the memory: bench fill/poke requests, otherwise DUT writes
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 8192; i++) mem[i] <= fill_val;
        end else if (poke_req) begin
            mem[poke_adr] <= poke_dat;
        end else if (tm_wen === 1'b1) begin
            mem[tm_adr] <= tm_wrt;
        end
    end

    // Running counts of write cycles and responses seen on the port
    always @(posedge clk) begin
        if (tm_wen === 1'b1) begin
            wen_cnt      = wen_cnt + 1;
            last_wen_adr = tm_adr;
        end
        if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        @(negedge clk);
        fill_val = v;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic poke(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_adr = a;
        poke_dat = d;
        poke_req = 1'b1;
        @(negedge clk);
        poke_req = 1'b0;
    endtask

    // Present a command for one edge; returns 1ns after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [6:0] x, input logic [6:0] y,
                         input logic [7:0] d);
        @(negedge clk);
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_dat   = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int   w0;
        int   r0;
        int   bad;
        logic got;

        n_checks  = 0;
        n_fail    = 0;
        wen_cnt   = 0;
        rsp_cnt   = 0;
        last_wen_adr = '0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_x     = 7'd0;
        cmd_y     = 7'd0;
        cmd_dat   = 8'h00;
        fill_req  = 1'b0;
        fill_val  = 8'h00;
        poke_req  = 1'b0;
        poke_adr  = '0;
        poke_dat  = 8'h00;

        fill(8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_wen", tm_wen, 0);
        check("rst_adr", tm_adr, 0);
        check("rst_rsp", rsp_valid, 0);

        // reset asserted between edges while a byte write is on the port
        issue(2'd2, 7'd5, 7'd2, 8'hAB);
        check("wb_pre_rst_wen", tm_wen, 1);
        #2 rst = 1'b1;
        #1;
        check("async_wen", tm_wen, 0);
        check("async_adr", tm_adr, 0);
        check("async_wrt", tm_wrt, 0);
        check("async_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("async_nowrite", mem[133], 8'h00);
        check("async_ready", cmd_ready, 1);

        // WRITE_CELL odd row: bits[3:2] replaced
        poke(13'h10A, 8'h5A);
        issue(2'd1, 7'd10, 7'd5, 8'h03);
        check("wc_rd_adr", tm_adr, 13'h10A);
        check("wc_rd_wen", tm_wen, 0);
        check("wc_rd_rsp", rsp_valid, 0);
        check("wc_rd_ready", cmd_ready, 0);
        tick();
        check("wc_mod_wrt", tm_wrt, 8'h5E);
        check("wc_mod_wen", tm_wen, 1);
        check("wc_mod_rsp", rsp_valid, 1);
        check("wc_mod_err", rsp_err, 0);
        tick();
        check("wc_ready", cmd_ready, 1);
        check("wc_wen_off", tm_wen, 0);
        check("wc_mem", mem[13'h10A], 8'h5E);

        // READ_CELL even row
        w0 = wen_cnt;
        issue(2'd0, 7'd10, 7'd4, 8'h00);
        check("rc_c1_ready", cmd_ready, 0);
        tick();
        check("rc_rsp", rsp_valid, 1);
        check("rc_dat", rsp_dat, 8'h16);
        check("rc_err", rsp_err, 0);
        tick();
        check("rc_ready", cmd_ready, 1);
        check("rc_no_wen", wen_cnt - w0, 0);

        // out-of-range cell commands
        w0 = wen_cnt;
        issue(2'd1, 7'd120, 7'd0, 8'h03);
        check("wc_oor_rsp", rsp_valid, 1);
        check("wc_oor_err", rsp_err, 1);
        check("wc_oor_wen", tm_wen, 0);
        tick();
        check("wc_oor_ready", cmd_ready, 1);
        issue(2'd0, 7'd0, 7'd96, 8'h00);
        check("rc_oor_err", rsp_err, 1);
        tick();
        check("oor_no_wen", wen_cnt - w0, 0);

        // WRITE_BYTE into status column, and out-of-range row
        w0 = wen_cnt;
        issue(2'd2, 7'd120, 7'd0, 8'h3F);
        check("wb_adr", tm_adr, 13'h078);
        check("wb_wrt", tm_wrt, 8'h3F);
        check("wb_wen", tm_wen, 1);
        check("wb_rsp", rsp_valid, 1);
        check("wb_err", rsp_err, 0);
        tick();
        check("wb_ready", cmd_ready, 1);
        check("wb_wen_cycles", wen_cnt - w0, 1);
        check("wb_mem", mem[13'h078], 8'h3F);
        issue(2'd2, 7'd3, 7'd96, 8'h11);
        check("wb_oor_err", rsp_err, 1);
        check("wb_oor_wen", tm_wen, 0);
        tick();

        // full CLEAR over a memory of 0xFF with one status byte 0x3F
        fill(8'hFF);
        poke(13'h078, 8'h3F);
        w0  = wen_cnt;
        r0  = rsp_cnt;
        got = 1'b0;
        issue(2'd3, 7'd0, 7'd0, 8'h00);
        for (int i = 0; i < 7000 && !got; i++) begin
            tick();
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        check("clr_done", got, 1);
        check("clr_wen_cycles", wen_cnt - w0, 5760);
        check("clr_last_adr", last_wen_adr, 13'h17F7);
        check("clr_done_wen", tm_wen, 0);
        check("clr_done_err", rsp_err, 0);
        tick();
        check("clr_ready", cmd_ready, 1);
        check("clr_one_rsp", rsp_cnt - r0, 1);
        bad = 0;
        for (int r = 0; r < 48; r++)
            for (int c = 0; c < 120; c++)
                if (mem[r * 128 + c] !== 8'h00) bad++;
        check("clr_play_zero", bad, 0);
        check("clr_status_3f", mem[13'h078], 8'h3F);
        check("clr_status_ff", mem[13'h07F], 8'hFF);
        check("clr_row47_c120", mem[13'h17F8], 8'hFF);
        check("clr_row48", mem[13'h1800], 8'hFF);

        // reset after 100 CLEAR writes
        fill(8'hFF);
        w0  = wen_cnt;
        r0  = rsp_cnt;
        got = 1'b0;
        issue(2'd3, 7'd0, 7'd0, 8'h00);
        for (int i = 0; i < 200 && !got; i++) begin
            if (wen_cnt - w0 >= 100) got = 1'b1;
            else tick();
        end
        check("pclr_reached", got, 1);
        rst = 1'b1;
        #1;
        check("pclr_wen_drop", tm_wen, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("pclr_writes", wen_cnt - w0, 100);
        check("pclr_no_rsp", rsp_cnt - r0, 0);
        check("pclr_c99", mem[99], 8'h00);
        check("pclr_c100", mem[100], 8'hFF);
        check("pclr_row1", mem[128], 8'hFF);
        poke(13'h10A, 8'hC7);
        issue(2'd0, 7'd10, 7'd5, 8'h00);
        tick();
        check("pclr_rc_rsp", rsp_valid, 1);
        check("pclr_rc_dat", rsp_dat, 8'h31);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
